// File: rtl/conv1_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : conv1_buf_pkg
// Purpose  : Shared CNN parameters for the first convolution layer and the
//            stages that follow it (window buffer, convolution sum, ...).
//            Also holds the window-tap index helper used by conv1_buf.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package conv1_buf_pkg;

  localparam int CNN_WIDTH     = 28;  // image width in pixels
  localparam int CNN_HEIGHT    = 28;  // image height in pixels
  localparam int CNN_DATA_BITS = 8;   // unsigned pixel width
  localparam int FILTER_SIZE   = 5;   // square filter edge length
  localparam int NUM_TAPS      = FILTER_SIZE * FILTER_SIZE;

  // Delay-line depth needed to expose a full window for a given image width.
  function automatic int linebuf_depth(input int width);
    return (FILTER_SIZE - 1) * width + FILTER_SIZE;
  endfunction

  // Delay-line entry (0 = newest) feeding window tap k, where tap k sits at
  // window row k/FILTER_SIZE (0 = top) and column k%FILTER_SIZE (0 = left).
  function automatic int tap_index(input int k, input int width);
    return (FILTER_SIZE - 1 - k / FILTER_SIZE) * width
         + (FILTER_SIZE - 1 - k % FILTER_SIZE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv1_linebuf.sv
`default_nettype none
// ============================================================================
// Module   : conv1_linebuf
// Purpose  : Plain shift-register delay line with every entry exposed as a
//            tap. No reset so it can map onto shift-register/LUT storage.
// Ports    : clk       - clock
//            shift_en  - shift by one, data_in becomes entry 0
//            data_in   - DATA_BITS input sample
//            taps      - flat DEPTH*DATA_BITS bus, entry i at [i*DATA_BITS +:]
// Revision : 1.0  initial release
// ============================================================================
module conv1_linebuf #(
  parameter int DEPTH     = 117,
  parameter int DATA_BITS = 8
) (
  input  logic                       clk,
  input  logic                       shift_en,
  input  logic [DATA_BITS-1:0]       data_in,
  output logic [DEPTH*DATA_BITS-1:0] taps
);

  logic [DATA_BITS-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (shift_en) begin
      mem[0] <= data_in;
      for (int i = 1; i < DEPTH; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_taps
      assign taps[i*DATA_BITS +: DATA_BITS] = mem[i];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/conv1_buf.sv
`default_nettype none
// ============================================================================
// Module   : conv1_buf
// Purpose  : 5x5 sliding-window generator for the first convolution layer.
//            Pixels arrive in raster order; a registered window plus a valid
//            strobe is produced for every pixel that completes a full window
//            inside the current frame.
// Ports    : clk            - clock, all state on rising edge
//            rst_n          - asynchronous active-low reset
//            valid_in       - data_in carries a pixel this cycle
//            data_in        - unsigned pixel
//            data_out_0..24 - registered window, k -> row k/5, col k%5
//            valid_out_buf  - window on data_out_* is valid this cycle
// Revision : 1.0  initial release
// ============================================================================
module conv1_buf
  import conv1_buf_pkg::*;
#(
  parameter int WIDTH     = CNN_WIDTH,
  parameter int HEIGHT    = CNN_HEIGHT,
  parameter int DATA_BITS = CNN_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_in,
  input  logic [DATA_BITS-1:0] data_in,
  output logic [DATA_BITS-1:0] data_out_0,
  output logic [DATA_BITS-1:0] data_out_1,
  output logic [DATA_BITS-1:0] data_out_2,
  output logic [DATA_BITS-1:0] data_out_3,
  output logic [DATA_BITS-1:0] data_out_4,
  output logic [DATA_BITS-1:0] data_out_5,
  output logic [DATA_BITS-1:0] data_out_6,
  output logic [DATA_BITS-1:0] data_out_7,
  output logic [DATA_BITS-1:0] data_out_8,
  output logic [DATA_BITS-1:0] data_out_9,
  output logic [DATA_BITS-1:0] data_out_10,
  output logic [DATA_BITS-1:0] data_out_11,
  output logic [DATA_BITS-1:0] data_out_12,
  output logic [DATA_BITS-1:0] data_out_13,
  output logic [DATA_BITS-1:0] data_out_14,
  output logic [DATA_BITS-1:0] data_out_15,
  output logic [DATA_BITS-1:0] data_out_16,
  output logic [DATA_BITS-1:0] data_out_17,
  output logic [DATA_BITS-1:0] data_out_18,
  output logic [DATA_BITS-1:0] data_out_19,
  output logic [DATA_BITS-1:0] data_out_20,
  output logic [DATA_BITS-1:0] data_out_21,
  output logic [DATA_BITS-1:0] data_out_22,
  output logic [DATA_BITS-1:0] data_out_23,
  output logic [DATA_BITS-1:0] data_out_24,
  output logic                 valid_out_buf
);

  localparam int DEPTH = linebuf_depth(WIDTH);
  localparam int COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_MIN  = COL_W'(FILTER_SIZE - 1);
  localparam logic [ROW_W-1:0] ROW_MIN  = ROW_W'(FILTER_SIZE - 1);

  logic [COL_W-1:0]           col;
  logic [ROW_W-1:0]           row;
  logic [DEPTH*DATA_BITS-1:0] taps;
  logic [DATA_BITS-1:0]       win_d [NUM_TAPS];
  logic [DATA_BITS-1:0]       win_q [NUM_TAPS];
  logic                       win_ok;
  logic                       unused_tail;

  conv1_linebuf #(
    .DEPTH     (DEPTH),
    .DATA_BITS (DATA_BITS)
  ) u_linebuf (
    .clk      (clk),
    .shift_en (valid_in),
    .data_in  (data_in),
    .taps     (taps)
  );

  // The window is taken from the line as it will look after this cycle's
  // shift: entry 0 is the incoming pixel, entry j>0 is today's entry j-1.
  // This lets the output register capture the window on the accepting edge.
  generate
    for (genvar k = 0; k < NUM_TAPS; k++) begin : g_win
      localparam int IDX = tap_index(k, WIDTH);
      if (IDX == 0) begin : g_new
        assign win_d[k] = data_in;
      end else begin : g_old
        assign win_d[k] = taps[(IDX-1)*DATA_BITS +: DATA_BITS];
      end
    end
  endgenerate

  // The oldest entry is only ever needed in its post-shift position.
  assign unused_tail = ^taps[DEPTH*DATA_BITS-1 -: DATA_BITS];

  // A window exists only once four full rows and four columns of the current
  // row are in the line; this also masks stale pixels from earlier rows and
  // frames that remain in the (unreset) delay line.
  assign win_ok = (row >= ROW_MIN) && (col >= COL_MIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col           <= '0;
      row           <= '0;
      valid_out_buf <= 1'b0;
      for (int k = 0; k < NUM_TAPS; k++) begin
        win_q[k] <= '0;
      end
    end else begin
      valid_out_buf <= valid_in && win_ok;
      if (valid_in) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
        if (win_ok) begin
          for (int k = 0; k < NUM_TAPS; k++) begin
            win_q[k] <= win_d[k];
          end
        end
      end
    end
  end

  assign data_out_0  = win_q[0];
  assign data_out_1  = win_q[1];
  assign data_out_2  = win_q[2];
  assign data_out_3  = win_q[3];
  assign data_out_4  = win_q[4];
  assign data_out_5  = win_q[5];
  assign data_out_6  = win_q[6];
  assign data_out_7  = win_q[7];
  assign data_out_8  = win_q[8];
  assign data_out_9  = win_q[9];
  assign data_out_10 = win_q[10];
  assign data_out_11 = win_q[11];
  assign data_out_12 = win_q[12];
  assign data_out_13 = win_q[13];
  assign data_out_14 = win_q[14];
  assign data_out_15 = win_q[15];
  assign data_out_16 = win_q[16];
  assign data_out_17 = win_q[17];
  assign data_out_18 = win_q[18];
  assign data_out_19 = win_q[19];
  assign data_out_20 = win_q[20];
  assign data_out_21 = win_q[21];
  assign data_out_22 = win_q[22];
  assign data_out_23 = win_q[23];
  assign data_out_24 = win_q[24];

endmodule
`default_nettype wire

// File: tb/tb_conv1_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv1_buf
// Purpose  : Directed self-checking bench for conv1_buf: ramp frames with
//            and without valid_in gaps, back-to-back frames, mid-frame reset.
// Ports    : none
// Revision : 1.0  initial release
// ============================================================================
module tb_conv1_buf;

  localparam int W    = 28;
  localparam int H    = 28;
  localparam int DB   = 8;
  localparam int NPIX = W * H;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid_in;
  logic [DB-1:0] data_in;
  logic [DB-1:0] dout [25];
  logic          valid_out;

  int tests = 0;
  int fails = 0;
  int mr, mc;        // bench's own position of the next pixel in the frame
  int frame_off;     // ramp offset of the frame being sent
  int pulses;        // valid windows seen since last clear

  always #5 clk = ~clk;

  conv1_buf #(.WIDTH(W), .HEIGHT(H), .DATA_BITS(DB)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in),
    .data_out_0(dout[0]),   .data_out_1(dout[1]),   .data_out_2(dout[2]),
    .data_out_3(dout[3]),   .data_out_4(dout[4]),   .data_out_5(dout[5]),
    .data_out_6(dout[6]),   .data_out_7(dout[7]),   .data_out_8(dout[8]),
    .data_out_9(dout[9]),   .data_out_10(dout[10]), .data_out_11(dout[11]),
    .data_out_12(dout[12]), .data_out_13(dout[13]), .data_out_14(dout[14]),
    .data_out_15(dout[15]), .data_out_16(dout[16]), .data_out_17(dout[17]),
    .data_out_18(dout[18]), .data_out_19(dout[19]), .data_out_20(dout[20]),
    .data_out_21(dout[21]), .data_out_22(dout[22]), .data_out_23(dout[23]),
    .data_out_24(dout[24]),
    .valid_out_buf(valid_out)
  );

  function automatic logic [DB-1:0] pix(input int r, input int c, input int off);
    return DB'((r * W + c + off) % 256);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_win(input string tag, input logic [25*DB-1:0] obs,
                           input logic [25*DB-1:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [25*DB-1:0] dout_vec();
    logic [25*DB-1:0] v;
    for (int k = 0; k < 25; k++) v[k*DB +: DB] = dout[k];
    return v;
  endfunction

  // Drive one pixel after 'gap' idle cycles; inputs change 1 time unit after
  // the edge and outputs are sampled there too.
  task automatic send(input logic [DB-1:0] v, input int gap);
    logic             exp_v;
    logic [25*DB-1:0] ew;
    repeat (gap) begin
      valid_in = 1'b0;
      @(posedge clk); #1;
      check("no_valid_after_idle", valid_out, 0);
    end
    valid_in = 1'b1;
    data_in  = v;
    @(posedge clk); #1;
    exp_v = (mr >= 4) && (mc >= 4);
    check("valid_strobe", valid_out, exp_v);
    if (exp_v && valid_out) begin
      pulses++;
      for (int k = 0; k < 25; k++)
        ew[k*DB +: DB] = pix(mr - 4 + k / 5, mc - 4 + k % 5, frame_off);
      check_win("window", dout_vec(), ew);
    end
    if (mc == W - 1) begin
      mc = 0;
      mr = (mr == H - 1) ? 0 : mr + 1;
    end else begin
      mc = mc + 1;
    end
  endtask

  task automatic send_range(input int off, input int first, input int last, input int gapmax);
    frame_off = off;
    for (int i = first; i <= last; i++)
      send(pix(i / W, i % W, off), (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
  endtask

  initial begin
    rst_n = 1'b0; valid_in = 1'b0; data_in = '0;
    mr = 0; mc = 0; frame_off = 0; pulses = 0;

    // ---- reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", valid_out, 0);
    check_win("reset_window", dout_vec(), '0);
    rst_n = 1'b1;

    // ---- ramp frame, continuous: first window right after pixel 116
    send_range(0, 0, 115, 0);
    check("pre_first_valid", valid_out, 0);
    send_range(0, 116, 116, 0);
    check("first_valid", valid_out, 1);
    check("first_d0", dout[0], 0);
    check("first_d4", dout[4], 4);
    check("first_d20", dout[20], 112);
    check("first_d24", dout[24], 116);
    send_range(0, 117, NPIX - 1, 0);
    valid_in = 1'b0;
    @(posedge clk); #1;
    check("idle_after_frame", valid_out, 0);
    check("ramp_pulses", pulses, 576);
    // last window is held: (23,23)=667%256=155, (27,27)=783%256=15
    check("hold_d0", dout[0], 155);
    check("hold_d24", dout[24], 15);

    // ---- same frame with random gaps (~50% duty)
    pulses = 0;
    send_range(0, 0, NPIX - 1, 2);
    valid_in = 1'b0;
    check("gap_pulses", pulses, 576);

    // ---- two back-to-back frames, second is ramp+1
    pulses = 0;
    send_range(0, 0, NPIX - 1, 0);
    send_range(1, 0, 115, 0);
    check("f2_pre_first_valid", valid_out, 0);
    send_range(1, 116, 116, 0);
    check("f2_first_valid", valid_out, 1);
    check("f2_first_d0", dout[0], 1);
    check("f2_first_d24", dout[24], 117);
    send_range(1, 117, NPIX - 1, 0);
    valid_in = 1'b0;
    check("b2b_pulses", pulses, 1152);

    // ---- reset after 300 pixels, then a fresh frame
    send_range(0, 0, 299, 0);
    valid_in = 1'b0;
    rst_n = 1'b0;
    #2;
    check("midrst_valid", valid_out, 0);
    check_win("midrst_window", dout_vec(), '0);
    @(posedge clk); #1;
    check("midrst_valid_hold", valid_out, 0);
    check_win("midrst_window_hold", dout_vec(), '0);
    rst_n = 1'b1;
    mr = 0; mc = 0; pulses = 0;
    send_range(0, 0, 116, 0);
    check("post_rst_first_valid", valid_out, 1);
    check("post_rst_d0", dout[0], 0);
    check("post_rst_d4", dout[4], 4);
    check("post_rst_d20", dout[20], 112);
    check("post_rst_d24", dout[24], 116);
    send_range(0, 117, NPIX - 1, 0);
    valid_in = 1'b0;
    @(posedge clk); #1;
    check("post_rst_pulses", pulses, 576);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
